// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets (addr[3:2]), the STATUS/CTRL/CLEAR bit positions,
// the serialiser state encoding and a helper that turns DIV into a bit period.
package mmio_uart_tx_pkg;

    // Register select values taken from addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    // STATUS bit positions
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 5;

    // CTRL bit positions (DIV occupies [15:0])
    localparam int CTRL_IRQ_EN  = 16;

    // CLEAR bit positions
    localparam int CLR_OVF      = 0;
    localparam int CLR_FLUSH    = 1;

    // Serialiser states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // A divisor of zero would stall the line forever, so it is treated as one.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX FIFO for the UART transmitter.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   push, push_data  write request and byte
//   pop              remove the head entry (ignored when empty)
//   flush            discard all entries; a push in the same cycle lands in
//                    the emptied FIFO
//   head_data        current head entry (combinational read)
//   push_ok          the push in this cycle is accepted
//   full, empty      occupancy flags
//   count            number of stored entries
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic                       push_ok,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_addr;
    logic             do_pop;

    assign full   = (count_reg == CNT_W'(DEPTH));
    assign empty  = (count_reg == '0);
    assign count  = count_reg;
    assign do_pop = pop & ~empty;

    // A full FIFO still accepts a push when the head leaves in the same cycle,
    // and a flush always makes room for the concurrent push.
    assign push_ok = push & (flush | ~full | do_pop);

    // After a flush the pointers restart at zero, so the concurrent push goes there.
    assign wr_addr = flush ? '0 : wr_ptr_reg;

    // The head is read combinationally so the serialiser can latch it in the
    // very cycle it pops.
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= push_ok ? PTR_W'(1) : '0;
            count_reg  <= push_ok ? CNT_W'(1) : '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART 8N1 transmitter on the CPU data port.
// Byte writes to TXDATA are queued and sent LSB first on uart_txd.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   ena, wea    access request and byte-lane write enables (wea==0 is a read)
//   addr        byte address; [31:4] must match BASE_ADDR, [3:2] select register
//   w_data      write data
//   r_data      registered read data
//   uart_txd    serial output, idle high
//   tx_irq      FIFO empty, serialiser idle and IRQ_EN set
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hBFAF_F000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [3:0]  wea,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        uart_txd,
    output logic        tx_irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       hit;
    logic       is_read;
    logic [1:0] reg_sel;
    logic       ctrl_wr;
    logic       ovf_clear;
    logic       push_drop;

    assign hit     = ena & (addr[31:4] == BASE_ADDR[31:4]);
    assign is_read = (wea == 4'b0000);
    assign reg_sel = addr[3:2];
    assign ctrl_wr = hit & (reg_sel == REG_CTRL);

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wea[3], w_data[31:17]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [7:0]       fifo_head;
    logic             fifo_push_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign fifo_push  = hit & wea[0] & (reg_sel == REG_TXDATA);
    assign fifo_flush = hit & wea[0] & (reg_sel == REG_CLEAR) & w_data[CLR_FLUSH];
    assign ovf_clear  = hit & wea[0] & (reg_sel == REG_CLEAR) & w_data[CLR_OVF];
    assign push_drop  = fifo_push & ~fifo_push_ok;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (w_data[7:0]),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (fifo_head),
        .push_ok   (fifo_push_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic [15:0] div_reg;
    logic        irq_en_reg;
    logic        ovf_reg;
    logic [31:0] r_data_reg;
    logic [31:0] status_word;
    logic [31:0] read_mux;
    logic        busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg    <= DIV_RESET;
            irq_en_reg <= 1'b0;
        end else if (ctrl_wr) begin
            if (wea[0]) div_reg[7:0]  <= w_data[7:0];
            if (wea[1]) div_reg[15:8] <= w_data[15:8];
            if (wea[2]) irq_en_reg    <= w_data[CTRL_IRQ_EN];
        end
    end

    // A drop in the same cycle as a clear leaves the flag set, so no
    // overflow is ever silently lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (push_drop) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clear) begin
            ovf_reg <= 1'b0;
        end
    end

    always_comb begin
        status_word                                  = '0;
        status_word[ST_BUSY]                         = busy;
        status_word[ST_FULL]                         = fifo_full;
        status_word[ST_EMPTY]                        = fifo_empty;
        status_word[ST_OVF]                          = ovf_reg;
        status_word[ST_COUNT_LSB +: ST_COUNT_W]      = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        read_mux = '0;
        case (reg_sel)
            REG_STATUS: read_mux = status_word;
            REG_CTRL:   read_mux = {15'd0, irq_en_reg, div_reg};
            default:    read_mux = '0;
        endcase
    end

    // Only reads move r_data; writes leave the last read value in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_reg <= '0;
        end else if (ena & is_read) begin
            r_data_reg <= hit ? read_mux : 32'd0;
        end
    end

    assign r_data = r_data_reg;

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    tx_state_t   state_reg,   state_next;
    logic [15:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  sh_reg,      sh_next;
    logic        bit_end;
    logic [15:0] period_m1;
    logic        txd_comb;

    assign bit_end   = (bit_cnt_reg == 16'd0);
    // Sampled at every bit start, so a DIV write takes effect at the next boundary.
    assign period_m1 = bit_period(div_reg) - 16'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= TX_IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            sh_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            sh_reg      <= sh_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        sh_next      = sh_reg;
        case (state_reg)
            TX_IDLE: begin
                if (fifo_pop) begin
                    state_next   = TX_START;
                    bit_cnt_next = period_m1;
                    sh_next      = fifo_head;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_next   = TX_DATA;
                    bit_idx_next = 3'd0;
                    bit_cnt_next = period_m1;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    bit_cnt_next = period_m1;
                    sh_next      = {1'b0, sh_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = TX_STOP;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (fifo_pop) begin
                        state_next   = TX_START;
                        bit_cnt_next = period_m1;
                        sh_next      = fifo_head;
                    end else begin
                        state_next   = TX_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    // Output logic; uart_txd is decoded from registers that reset
    // asynchronously, so reset drives the line high immediately.
    always_comb begin
        fifo_pop = 1'b0;
        txd_comb = 1'b1;
        busy     = (state_reg != TX_IDLE);
        case (state_reg)
            TX_IDLE: begin
                txd_comb = 1'b1;
                fifo_pop = ~fifo_empty;
            end
            TX_START: begin
                txd_comb = 1'b0;
            end
            TX_DATA: begin
                txd_comb = sh_reg[0];
            end
            TX_STOP: begin
                txd_comb = 1'b1;
                fifo_pop = bit_end & ~fifo_empty;
            end
            default: begin
                txd_comb = 1'b1;
            end
        endcase
    end

    assign uart_txd = txd_comb;
    assign tx_irq   = irq_en_reg & fifo_empty & (state_reg == TX_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hBFAF_F000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [3:0]  wea = 4'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] w_data = 32'b0;
    logic [31:0] r_data;
    logic        uart_txd;
    logic        tx_irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural model of the CTRL register
    logic [15:0] m_div = 16'd434;
    logic        m_irq = 1'b0;

    // Frames decoded from the serial line
    logic [7:0] rx_q[$];
    bit         rx_stop[$];
    int         rx_start[$];

    logic [7:0] first_byte;

    mmio_uart_tx dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .wea      (wea),
        .addr     (addr),
        .w_data   (w_data),
        .r_data   (r_data),
        .uart_txd (uart_txd),
        .tx_irq   (tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // UART receiver: samples the middle of each bit using the model divisor.
    initial begin : monitor
        int p;
        int st;
        int off;
        int tgt;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && uart_txd === 1'b0) begin
                p   = (m_div == 16'd0) ? 1 : int'(m_div);
                st  = cyc;
                off = 0;
                for (int i = 0; i < 8; i++) begin
                    tgt = p * (1 + i) + p / 2;
                    repeat (tgt - off) @(negedge clk);
                    off = tgt;
                    b[i] = uart_txd;
                end
                tgt = 9 * p + p / 2;
                repeat (tgt - off) @(negedge clk);
                rx_q.push_back(b);
                rx_stop.push_back(uart_txd === 1'b1);
                rx_start.push_back(st);
            end
        end
    end

    function automatic logic [31:0] st_word(input bit busy, input bit full,
                                            input bit empty, input bit ovf, input int cnt);
        st_word = (32'(cnt) << 8) | {28'd0, ovf, empty, full, busy};
    endfunction

    function automatic int period_of(input logic [15:0] d);
        period_of = (d == 16'd0) ? 1 : int'(d);
    endfunction

    // Bus tasks: called on a falling edge, return one cycle later on a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        ena = 1'b1; wea = we; addr = a; w_data = d;
        @(negedge clk);
        ena = 1'b0; wea = 4'b0;
        if (a[31:4] == BASE[31:4] && a[3:2] == 2'd2) begin
            if (we[0]) m_div[7:0]  = d[7:0];
            if (we[1]) m_div[15:8] = d[15:8];
            if (we[2]) m_irq       = d[16];
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        ena = 1'b1; wea = 4'b0; addr = a;
        @(negedge clk);
        ena = 1'b0;
        d = r_data;
    endtask

    task automatic clear_rx();
        rx_q.delete(); rx_stop.delete(); rx_start.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus_read(BASE + 32'h4, s);
            if (s[0] == 1'b0 && s[2] == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        chk32("reset_txd", {31'd0, uart_txd}, 32'd1);
        chk32("reset_irq", {31'd0, tx_irq}, 32'd0);
        chk32("reset_rdata", r_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus_read(BASE + 32'h4, d);
        chk32("reset_status", d, st_word(0, 0, 1, 0, 0));
        bus_read(BASE + 32'h8, d);
        chk32("reset_ctrl", d, {15'd0, m_irq, m_div});
    endtask

    task automatic test_frame_exact();
        logic [31:0] d;
        logic [7:0]  v;
        int lat;
        int bad;
        int first_bad;
        logic e;
        bit ok;
        bus_write(BASE + 32'h8, 4'b0011, 32'd4);
        clear_rx();
        v = 8'h55;
        bus_write(BASE, 4'b0001, {24'd0, v});
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (uart_txd === 1'b0) break;
        end
        chk32("frame_start_latency", lat, 1);
        bad = 0; first_bad = -1;
        for (int k = 0; k < 44; k++) begin
            if (k < 4) e = 1'b0;
            else if (k < 36) e = v[(k - 4) / 4];
            else e = 1'b1;
            if (uart_txd !== e) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_waveform: %0d wrong cycles, first at %0d, expected 0 wrong", bad, first_bad);
        end else begin
            $display("ok   frame_waveform: 0x55 at 4 cycles/bit");
        end
        bus_write(BASE, 4'b0001, 32'h0000_00A5);
        bus_read(BASE + 32'h4, d);
        chk32("status_queued", d, st_word(0, 0, 0, 0, 1));
        bus_read(BASE + 32'h4, d);
        chk32("status_busy", d, st_word(1, 0, 1, 0, 0));
        wait_idle(100, ok);
        chk32("frame2_idle", {31'd0, ok}, 32'd1);
        chk32("frame_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk32("frame_rx0", {24'd0, rx_q[0]}, 32'h55);
            chk32("frame_rx1", {24'd0, rx_q[1]}, 32'hA5);
            chk32("frame_stop", {30'd0, rx_stop[0], rx_stop[1]}, 32'd3);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [15:0] dv;
        int n;
        bit ok;
        for (int r = 0; r < 4; r++) begin
            dv = 16'($urandom_range(0, 5));
            bus_write(BASE + 32'h8, 4'b0011, {16'd0, dv});
            clear_rx();
            exp_q.delete();
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(BASE, 4'b0001, {24'd0, b});
            end
            wait_idle(400, ok);
            chk32($sformatf("b2b_idle_r%0d", r), {31'd0, ok}, 32'd1);
            chk32($sformatf("b2b_count_r%0d", r), rx_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                chk32($sformatf("b2b_byte_r%0d_%0d", r, i),
                      {23'd0, rx_stop[i], rx_q[i]}, {23'd1, exp_q[i]});
                if (i > 0)
                    chk32($sformatf("b2b_gap_r%0d_%0d", r, i),
                          rx_start[i] - rx_start[i-1], 10 * period_of(dv));
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  b;
        bus_write(BASE + 32'h8, 4'b0011, 32'd100);
        clear_rx();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i == 0) first_byte = b;
            bus_write(BASE, 4'b0001, {24'd0, b});
        end
        bus_read(BASE + 32'h4, d);
        chk32("ovf_full", d, st_word(1, 1, 0, 0, 16));
        bus_write(BASE, 4'b0001, 32'($urandom));
        bus_read(BASE + 32'h4, d);
        chk32("ovf_set", d, st_word(1, 1, 0, 1, 16));
        bus_write(BASE + 32'hC, 4'b0001, 32'd1);
        bus_read(BASE + 32'h4, d);
        chk32("ovf_cleared", d, st_word(1, 1, 0, 0, 16));
    endtask

    task automatic test_flush();
        logic [31:0] d;
        bit ok;
        int bad;
        bus_write(BASE + 32'hC, 4'b0001, 32'd2);
        bus_read(BASE + 32'h4, d);
        chk32("flush_status", d, st_word(1, 0, 1, 0, 0));
        wait_idle(1200, ok);
        chk32("flush_idle", {31'd0, ok}, 32'd1);
        chk32("flush_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1)
            chk32("flush_inflight", {23'd0, rx_stop[0], rx_q[0]}, {23'd1, first_byte});
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (uart_txd !== 1'b1) bad++;
            @(negedge clk);
        end
        chk32("flush_line_idle", bad, 0);
        bus_read(BASE + 32'h4, d);
        chk32("flush_status_end", d, st_word(0, 0, 1, 0, 0));
    endtask

    task automatic test_ctrl_lanes();
        logic [31:0] d;
        logic [3:0]  we;
        bus_write(BASE + 32'h8, 4'b1111, 32'h0001_01B2);
        chk32("irq_enabled", {31'd0, tx_irq}, 32'd1);
        bus_write(BASE + 32'h8, 4'b0001, 32'h0001_1234);
        bus_read(BASE + 32'h8, d);
        chk32("ctrl_lane0", d, {15'd0, m_irq, m_div});
        chk32("irq_kept", {31'd0, tx_irq}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            we = 4'($urandom_range(1, 15));
            bus_write(BASE + 32'h8, we, 32'($urandom));
            bus_read(BASE + 32'h8, d);
            chk32($sformatf("ctrl_rand_%0d_we%h", i, we), d, {15'd0, m_irq, m_div});
        end
        bus_write(BASE + 32'h8, 4'b0111, 32'h0001_01B2);
        bus_write(BASE + 32'h18, 4'b1111, 32'h0000_0000);
        bus_read(BASE + 32'h8, d);
        chk32("ctrl_miss_write", d, 32'h0001_01B2);
        bus_read(BASE + 32'h10, d);
        chk32("read_miss", d, 32'd0);
        bus_read(BASE + 32'h8, d);
        bus_read(BASE + 32'h0, d);
        chk32("read_txdata", d, 32'd0);
        bus_read(BASE + 32'h8, d);
        bus_read(BASE + 32'hC, d);
        chk32("read_clear", d, 32'd0);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int bad;
        bus_write(BASE + 32'h8, 4'b0111, 32'd4);
        clear_rx();
        bus_write(BASE, 4'b0001, 32'h00);
        bus_write(BASE, 4'b0001, 32'hFF);
        // Frame 0x00 started one cycle after its push; move into data bit 2.
        repeat (12) @(negedge clk);
        chk32("midframe_low", {31'd0, uart_txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk32("reset_async_txd", {31'd0, uart_txd}, 32'd1);
        m_div = 16'd434;
        m_irq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(BASE + 32'h4, d);
        chk32("post_reset_status", d, st_word(0, 0, 1, 0, 0));
        chk32("post_reset_irq", {31'd0, tx_irq}, 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (uart_txd !== 1'b1) bad++;
            @(negedge clk);
        end
        chk32("post_reset_no_frame", bad, 0);
        bus_read(BASE + 32'h8, d);
        chk32("post_reset_ctrl", d, 32'h0000_01B2);
        clear_rx();
    endtask

    initial begin
        test_reset();
        test_frame_exact();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_ctrl_lanes();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
